button_debounce: RTL and testbench



---
 rtl/debounce_pkg.sv | 14 +
 rtl/sync_2ff.sv | 23 ++
 rtl/button_debounce.sv | 115 +++++++++++
 tb/tb_button_debounce.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debounce path.
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } debounce_state_e;

  // 20 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous pads, with a selectable reset value.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RESET_VAL;
      q  <= RESET_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Debounces an active-low push-button: synchronised level, press/release strobes and a toggle flag.
module button_debounce
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic            CLOCK_50,
  input  logic            reset_n,
  input  logic            btn_n,
  output logic            btn_level,
  output logic            press_pulse,
  output logic            release_pulse,
  output logic            toggle_state,
  output debounce_state_e state_dbg
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            s2;
  debounce_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            accept_press, accept_release;
  logic            level_d, toggle_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .d     (btn_n),
    .q     (s2)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample of the opposite level while waiting restarts qualification.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (!s2) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (s2) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (s2) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!s2) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    accept_press   = (state_q == PRESS_WAIT)   && !s2 && (cnt_q == CNT_MAX);
    accept_release = (state_q == RELEASE_WAIT) &&  s2 && (cnt_q == CNT_MAX);
    level_d        = btn_level;
    if (accept_press)   level_d = 1'b1;
    if (accept_release) level_d = 1'b0;
    toggle_d       = toggle_state ^ accept_press;
  end

  // Strobes are loaded every cycle, so they drop on the edge after they rise.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      toggle_state  <= 1'b0;
    end else begin
      btn_level     <= level_d;
      press_pulse   <= accept_press;
      release_pulse <= accept_release;
      toggle_state  <= toggle_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES = 4 on a 20 ns clock.
module tb_button_debounce;
  import debounce_pkg::*;

  logic            CLOCK_50;
  logic            reset_n;
  logic            btn_n;
  logic            btn_level;
  logic            press_pulse;
  logic            release_pulse;
  logic            toggle_state;
  debounce_state_e state_dbg;

  int checks      = 0;
  int failures    = 0;
  int press_cnt   = 0;
  int release_cnt = 0;
  int overlap_cnt = 0;
  int p0, r0;

  button_debounce #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset_n       (reset_n),
    .btn_n         (btn_n),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .toggle_state  (toggle_state),
    .state_dbg     (state_dbg)
  );

  // clock / reset block
  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // pulse monitor sampled on the falling edge
  always @(negedge CLOCK_50) begin
    if (press_pulse === 1'b1)   press_cnt++;
    if (release_pulse === 1'b1) release_cnt++;
    if (press_pulse === 1'b1 && release_pulse === 1'b1) overlap_cnt++;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    btn_n   = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // 1: asynchronous reset between edges, then idle
    #5 reset_n = 1'b0;
    #2;
    check("reset_outputs", {btn_level, press_pulse, release_pulse, toggle_state}, 4'b0000);
    check("reset_state", state_dbg, RELEASED);
    #4 reset_n = 1'b1;
    for (int k = 1; k <= 20; k++)
      check("idle_outputs", {btn_level, press_pulse, release_pulse, toggle_state}, 4'b0000);
    tick(20);
    check("idle_no_press", press_cnt, 0);

    // 3: bounce rejected (low 3, high 2, low 2, high)
    btn_n = 1'b0;
    tick(3);
    check("bounce_in_press_wait", state_dbg, PRESS_WAIT);
    btn_n = 1'b1;
    tick(2);
    btn_n = 1'b0;
    tick(2);
    btn_n = 1'b1;
    tick(12);
    check("bounce_no_press", press_cnt, 0);
    check("bounce_level", btn_level, 1'b0);
    check("bounce_toggle", toggle_state, 1'b0);
    check("bounce_state", state_dbg, RELEASED);

    // 2: clean press, pulse on the 7th edge after the first low sample
    btn_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("press_pulse_e%0d", k), press_pulse, (k == 7));
      check($sformatf("press_level_e%0d", k), btn_level, (k >= 7));
    end
    tick(40);
    check("press_count", press_cnt, 1);
    check("press_toggle", toggle_state, 1'b1);
    check("press_held_state", state_dbg, PRESSED);

    // 4: release with bounce (high 2, low 1, then high)
    btn_n = 1'b1;
    tick(2);
    btn_n = 1'b0;
    tick();
    btn_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("release_pulse_e%0d", k), release_pulse, (k == 7));
      check($sformatf("release_level_e%0d", k), btn_level, (k < 7));
    end
    check("release_count", release_cnt, 1);
    check("release_no_press", press_cnt, 1);
    check("release_toggle", toggle_state, 1'b1);

    // 5: reset in the middle of press qualification
    btn_n = 1'b0;
    tick(3);
    check("mid_reset_pre_state", state_dbg, PRESS_WAIT);
    #5 reset_n = 1'b0;
    #1;
    check("mid_reset_toggle", toggle_state, 1'b0);
    check("mid_reset_state", state_dbg, RELEASED);
    tick(3);
    #5 reset_n = 1'b1;
    check("mid_reset_no_press", press_cnt, 1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("post_reset_pulse_e%0d", k), press_pulse, (k == 7));
    end
    check("post_reset_count", press_cnt, 2);
    check("post_reset_toggle", toggle_state, 1'b1);
    check("post_reset_level", btn_level, 1'b1);

    // 6: four press/release pairs from a fresh reset
    btn_n = 1'b1;
    #5 reset_n = 1'b0;
    #5 reset_n = 1'b1;
    tick(3);
    p0 = press_cnt;
    r0 = release_cnt;
    for (int i = 0; i < 4; i++) begin
      btn_n = 1'b0;
      tick(10);
      check($sformatf("rep_toggle_%0d", i), toggle_state, (i % 2 == 0));
      check($sformatf("rep_level_hi_%0d", i), btn_level, 1'b1);
      btn_n = 1'b1;
      tick(10);
      check($sformatf("rep_level_lo_%0d", i), btn_level, 1'b0);
    end
    check("rep_press_count", press_cnt - p0, 4);
    check("rep_release_count", release_cnt - r0, 4);
    check("no_pulse_overlap", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
